keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Input-side counterpart of the multiplexed 7-segment display driver: the display scans digits out, this block scans a 4x4 hex keypad in (Pmod KYPD) on the board's 4 column / 4 row lines. It drives one column low at a time and samples the rows. After debouncing it reports a hex key code with a one-cycle valid strobe and a held-down level. Demo tops feed its outputs into LED/word logic in the same way as they use button click pulses.

Parameters:
SCAN_DIV, 100000, clock cycles each column is driven (1 ms at 100 MHz); legal range >= 4
DEBOUNCE_SCANS, 4, consecutive identical full scans required before a change is accepted; legal range >= 1

Ports:
CLK  input  1  system clock, all logic on posedge
RESETN  input  1  asynchronous, active-low reset
ROW  input  4  keypad row lines, active-low (pulled up on board), asynchronous to CLK
COL  output  4  keypad column drives, active-low, exactly one bit low at all times
KEY  output  4  hex code of last accepted key
KEY_VALID  output  1  one-cycle pulse when a new key press is accepted
KEY_DOWN  output  1  high while the accepted key is held

Behaviour:
- One clock; reset is asynchronous and active-low (RESETN); all flops clear immediately on RESETN low.
- Reset values: COL=4'b1110, KEY=0, KEY_VALID=0, KEY_DOWN=0, divider=0, column index=0, debounce state = no key, count 0.
- ROW passes through a 2-flop synchronizer; the sample point uses only the synchronized value.
- Divider counts 0..SCAN_DIV-1 per column. At terminal count: sample synchronized ROW for current column, advance column (3 wraps to 0), COL = ~(1<<col).
- Snapshot per full scan (columns 0..3): record every (row,col) read low.
  - Exactly one low -> snapshot = that key.
  - Zero lows -> snapshot = NONE.
  - Two or more lows (ghosting/multi-press) -> snapshot = NONE.
- Key map, row r / col c -> KEY:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce, evaluated at end of each full scan (column 3 terminal count):
  - snapshot == candidate: cnt = min(cnt+1, DEBOUNCE_SCANS).
  - Otherwise: candidate = snapshot, cnt = 1.
  - When cnt reaches DEBOUNCE_SCANS and candidate != committed: commit.
- Commit rules:
  - NONE -> key k: KEY=k, KEY_DOWN=1, KEY_VALID pulses on the next cycle.
  - Key -> different key with no NONE between: treated as a new press (KEY updated, KEY_VALID pulses, KEY_DOWN stays 1).
  - Key -> NONE: KEY_DOWN=0, KEY retained, no pulse.
- Latency: a press stable from the start of a scan is accepted DEBOUNCE_SCANS*4*SCAN_DIV cycles later, +1 cycle to KEY_VALID.
- A bounce shorter than DEBOUNCE_SCANS scans produces no output change.
- KEY_VALID never exceeds 1 cycle. It never asserts during reset or the first full scan after reset.
- Reset mid-scan aborts the scan. Scanning restarts at column 0 with state cleared, and no pulse is emitted for a key held through reset until it is re-debounced.

Decomposition:
- Shared package: keymap constant (16-entry row/col -> hex table), NONE snapshot encoding, COL reset pattern.
- One sub-module, keypad_debounce: snapshot candidate/counter/commit logic. Inputs: scan_done strobe and snapshot. Outputs: KEY, KEY_VALID, KEY_DOWN.
- Divider, column sequencing and synchronizer stay in keypad_scanner.

Test Plan:
(All with SCAN_DIV=4, DEBOUNCE_SCANS=2; bench models the keypad as row = AND of pressed-key columns.)
- Reset -> COL=1110, KEY=0, KEY_VALID=0, KEY_DOWN=0. COL sequence is 1110,1101,1011,0111, each held 4 cycles, wrapping.
- Hold key '5' (r1,c1) from reset release -> KEY=5 and KEY_DOWN=1 after the 2nd scan end; single KEY_VALID pulse about 33 cycles after release; no further pulse while held.
- Release '5' -> KEY_DOWN=0 after 2 NONE scans; KEY stays 5; no pulse.
- Press 'D' (r3,c3) for 1 scan only, bouncing -> no KEY_VALID, KEY_DOWN stays 0.
- Hold 'A' then switch to '0' without release -> two pulses, KEY=A then KEY=0, KEY_DOWN continuously 1. Press '1' and '2' together -> NONE, no pulse.
- Assert RESETN low mid-scan while '7' held -> outputs clear at once. After release, '7' is re-accepted with a fresh pulse after 2 scans.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 hex keypad scanner.
//   SNAP_NONE  : 5-bit snapshot encoding meaning "no single key seen"
//                (bit 4 set); a valid key is {1'b0, hex_code}.
//   COL_RESET  : column drive pattern out of reset (column 0 driven low).
//   KEYMAP     : row/column position -> hex code, indexed by {row, col}.
//   count_lows : number of asserted bits in a 4-bit active-high vector.
//   low_index  : position of the lowest asserted bit (valid when exactly one).
package keypad_scanner_pkg;

  localparam logic [4:0] SNAP_NONE = 5'b1_0000;
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Physical layout of the Pmod KYPD: row 0 reads 1 2 3 A left to right.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic [2:0] count_lows(input logic [3:0] lows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, lows[i]};
    end
    return n;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] lows);
    logic [1:0] idx;
    casez (lows)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Snapshot debouncer for the keypad scanner.
//   clk, rst_n   : clock, asynchronous active-low reset
//   scan_done_i  : one-cycle strobe at the end of every full 4-column scan
//   snapshot_i   : result of that scan ({1'b0,code} or SNAP_NONE)
//   key_o        : hex code of the last accepted key (kept after release)
//   key_valid_o  : one-cycle pulse, the cycle after a new press is accepted
//   key_down_o   : high while the accepted key is still held
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_done_i,
  input  logic [4:0] snapshot_i,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_down_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [4:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       committed_q, committed_d;
  logic [3:0]       key_q, key_d;
  logic             key_down_q, key_down_d;
  logic             pend_q, pend_d;
  logic             key_valid_q, key_valid_d;

  // Candidate tracking and commit decision, evaluated once per full scan.
  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    key_d       = key_q;
    key_down_d  = key_down_q;
    pend_d      = 1'b0;
    // The pulse is delayed one cycle behind the KEY update.
    key_valid_d = pend_q;
    if (scan_done_i) begin
      if (snapshot_i == cand_q) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        cand_d = snapshot_i;
        cnt_d  = CNT_ONE;
      end
      if ((cnt_d == CNT_MAX) && (cand_d != committed_q)) begin
        committed_d = cand_d;
        if (cand_d == SNAP_NONE) begin
          // Release: KEY keeps the last code, no pulse.
          key_down_d = 1'b0;
        end else begin
          // Fresh press or key-to-key roll: both count as a new press.
          key_d      = cand_d[3:0];
          key_down_d = 1'b1;
          pend_d     = 1'b1;
        end
      end else begin
        committed_d = committed_q;
      end
    end else begin
      cand_d = cand_q;
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q      <= SNAP_NONE;
      cnt_q       <= {CNT_W{1'b0}};
      committed_q <= SNAP_NONE;
      key_q       <= 4'h0;
      key_down_q  <= 1'b0;
      pend_q      <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      key_q       <= key_d;
      key_down_q  <= key_down_d;
      pend_q      <= pend_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign key_down_o  = key_down_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner (Pmod KYPD).
//   CLK       : system clock
//   RESETN    : asynchronous active-low reset
//   ROW[3:0]  : row lines, active-low, asynchronous to CLK
//   COL[3:0]  : column drives, active-low, exactly one low at a time
//   KEY[3:0]  : hex code of the last accepted key
//   KEY_VALID : one-cycle pulse on each newly accepted press
//   KEY_DOWN  : high while the accepted key is held
// Each column is driven for SCAN_DIV cycles; rows are sampled on the last
// cycle of the column. A full scan yields a snapshot that feeds the debouncer.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY,
  output logic       KEY_VALID,
  output logic       KEY_DOWN
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_sync_q, row_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  // Hits so far in this scan: 0, 1, or 2 meaning "two or more".
  logic [1:0]       hit_cnt_q, hit_cnt_d;
  logic [3:0]       hit_key_q, hit_key_d;

  logic [3:0] col_lows_s;
  logic [2:0] col_cnt_s;
  logic [1:0] col_hits_s;
  logic [3:0] col_key_s;
  logic [2:0] hit_sum_s;
  logic [1:0] total_s;
  logic [3:0] merged_key_s;
  logic [4:0] snapshot_s;
  logic       tc_s;
  logic       scan_done_s;

  // Classify the current column's rows and fold them into the scan result.
  always_comb begin
    col_lows_s  = ~row_sync_q;
    col_cnt_s   = count_lows(col_lows_s);
    col_key_s   = key_code(low_index(col_lows_s), col_idx_q);
    tc_s        = (div_q == DIV_LAST);
    scan_done_s = tc_s && (col_idx_q == 2'd3);
    if (col_cnt_s >= 3'd2) begin
      col_hits_s = 2'd2;
    end else begin
      col_hits_s = col_cnt_s[1:0];
    end
    hit_sum_s = {1'b0, hit_cnt_q} + {1'b0, col_hits_s};
    if (hit_sum_s >= 3'd2) begin
      total_s = 2'd2;
    end else begin
      total_s = hit_sum_s[1:0];
    end
    if (hit_cnt_q == 2'd0) begin
      merged_key_s = col_key_s;
    end else begin
      merged_key_s = hit_key_q;
    end
    // Ghosting / multi-press collapses to NONE, same as no key.
    if (total_s == 2'd1) begin
      snapshot_s = {1'b0, merged_key_s};
    end else begin
      snapshot_s = SNAP_NONE;
    end
  end

  // Synchronizer, divider, column sequencing and per-scan accumulation.
  always_comb begin
    row_meta_d = ROW;
    row_sync_d = row_meta_q;
    div_d      = div_q;
    col_idx_d  = col_idx_q;
    col_d      = col_q;
    hit_cnt_d  = hit_cnt_q;
    hit_key_d  = hit_key_q;
    if (tc_s) begin
      div_d     = {DIV_W{1'b0}};
      col_idx_d = col_idx_q + 2'd1;
      col_d     = ~(4'b0001 << col_idx_d);
      if (scan_done_s) begin
        hit_cnt_d = 2'd0;
        hit_key_d = 4'h0;
      end else begin
        hit_cnt_d = total_s;
        hit_key_d = merged_key_s;
      end
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Scanner state registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= {DIV_W{1'b0}};
      col_idx_q  <= 2'd0;
      col_q      <= COL_RESET;
      hit_cnt_q  <= 2'd0;
      hit_key_q  <= 4'h0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      hit_cnt_q  <= hit_cnt_d;
      hit_key_q  <= hit_key_d;
    end
  end

  assign COL = col_q;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (CLK),
    .rst_n      (RESETN),
    .scan_done_i(scan_done_s),
    .snapshot_i (snapshot_s),
    .key_o      (KEY),
    .key_valid_o(KEY_VALID),
    .key_down_o (KEY_DOWN)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// The keypad is modelled as a set of pressed positions; a row reads low when
// any pressed key in that row sits on the column currently driven low.
// Pressed sets only change right after a scan boundary, so each scan sees one
// set. The reference keeps a history of per-scan snapshots and accepts a new
// state once the last DEBOUNCE_SCANS snapshots agree.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_LEN = 4 * SCAN_DIV;
  localparam logic [4:0] NONE = 5'h10;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] KEY;
  logic       KEY_VALID;
  logic       KEY_DOWN;

  logic [15:0] mask = 16'h0000;
  int checks = 0;
  int errors = 0;
  int t = 0;

  logic [3:0] tb_map [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  logic [4:0] hist [$];
  logic [4:0] accepted;
  logic [3:0] exp_key;
  logic       exp_down;
  logic       pend;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .ROW      (ROW),
    .COL      (COL),
    .KEY      (KEY),
    .KEY_VALID(KEY_VALID),
    .KEY_DOWN (KEY_DOWN)
  );

  always #5 CLK = ~CLK;

  // Keypad matrix: pressed key at (r,c) pulls row r low while column c is low.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask[r*4+c] && !COL[c]) ROW[r] = 1'b0;
      end
    end
  end

  function automatic logic [4:0] snap_of(input logic [15:0] m);
    if ($countones(m) == 1) begin
      for (int i = 0; i < 16; i++) begin
        if (m[i]) return {1'b0, tb_map[i]};
      end
    end
    return NONE;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    accepted = NONE;
    exp_key  = 4'h0;
    exp_down = 1'b0;
    pend     = 1'b0;
    t        = 0;
  endtask

  task automatic scan_end();
    logic [4:0] s;
    logic       same;
    s = snap_of(mask);
    hist.push_back(s);
    if (hist.size() > DEB) void'(hist.pop_front());
    same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != s) same = 1'b0;
    if (same && s != accepted) begin
      accepted = s;
      if (s == NONE) begin
        exp_down = 1'b0;
      end else begin
        exp_key  = s[3:0];
        exp_down = 1'b1;
        pend     = 1'b1;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] exp_col;
    logic       exp_valid;
    @(posedge CLK);
    t++;
    if (t % SCAN_LEN == 0) scan_end();
    @(negedge CLK);
    exp_valid = 1'b0;
    if (t % SCAN_LEN == 1) begin
      exp_valid = pend;
      pend = 1'b0;
    end
    exp_col = ~(4'b0001 << ((t / SCAN_DIV) % 4));
    check("col", {4'h0, COL}, {4'h0, exp_col});
    check("key", {4'h0, KEY}, {4'h0, exp_key});
    check("key_down", {7'h00, KEY_DOWN}, {7'h00, exp_down});
    check("key_valid", {7'h00, KEY_VALID}, {7'h00, exp_valid});
  endtask

  task automatic run_scans(input int n, input logic [15:0] m);
    mask = m;
    repeat (n * SCAN_LEN) tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_col", {4'h0, COL}, 8'h0E);
    check("rst_key", {4'h0, KEY}, 8'h00);
    check("rst_valid", {7'h00, KEY_VALID}, 8'h00);
    check("rst_down", {7'h00, KEY_DOWN}, 8'h00);
  endtask

  initial begin
    logic [15:0] m;
    int i;
    int j;
    model_reset();
    mask = 16'h0020;
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs();

    // '5' held from reset release, then released.
    RESETN = 1'b1;
    run_scans(4, 16'h0020);
    run_scans(3, 16'h0000);

    // 'D' for a single scan: a bounce, must not be accepted.
    run_scans(1, 16'h8000);
    run_scans(3, 16'h0000);

    // 'A' rolled straight onto '0', then released.
    run_scans(3, 16'h0008);
    run_scans(3, 16'h1000);
    run_scans(3, 16'h0000);

    // '1' and '2' together: multi-press reads as no key.
    run_scans(3, 16'h0003);
    run_scans(2, 16'h0000);

    // Randomized key activity.
    m = 16'h0000;
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: m = m;
        1: m = 16'h0000;
        2: m = 16'h0001 << $urandom_range(0, 15);
        default: begin
          i = $urandom_range(0, 15);
          j = (i + $urandom_range(1, 15)) % 16;
          m = (16'h0001 << i) | (16'h0001 << j);
        end
      endcase
      run_scans($urandom_range(1, 3), m);
    end
    run_scans(3, 16'h0000);

    // '7' held, reset pulled mid-scan, then re-accepted after release.
    run_scans(3, 16'h0100);
    repeat (7) tick();
    RESETN = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    run_scans(4, 16'h0100);
    run_scans(3, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
